// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: owner state encoding and
// the default starvation bound for debug-port requests.
package dmem_arb_pkg;

    // Who drives the single data-memory port in the current cycle.
    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

    // Default number of consecutive cycles a debug request may wait while
    // the CPU keeps the port busy (legal range 1..15).
    localparam int STARVE_LIMIT_DEF = 4;

    // Width of the starvation counter; wide enough for the full 1..15 range.
    localparam int WAIT_W = 4;

endpackage

// File: rtl/dmem_arb_if.sv
// Bus bundle for the data-memory arbiter: CPU requester, debug/loader
// requester and the single dmem port. The slave modport is the arbiter's
// view; the master modport is the environment's view (requesters + memory).
interface dmem_arb_if;

    // CPU data access port
    logic        c_req;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [3:0]  c_we;
    logic [31:0] c_rdata;
    logic        c_stall;

    // Debug / loader port
    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_we;
    logic        d_gnt;
    logic [31:0] d_rdata;
    logic        d_valid;

    // Data memory port (combinational read of daddr)
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dwe;
    logic [31:0] drdata;

    modport slave (
        input  c_req, c_addr, c_wdata, c_we,
        output c_rdata, c_stall,
        input  d_req, d_addr, d_wdata, d_we,
        output d_gnt, d_rdata, d_valid,
        output daddr, dwdata, dwe,
        input  drdata
    );

    modport master (
        output c_req, c_addr, c_wdata, c_we,
        input  c_rdata, c_stall,
        output d_req, d_addr, d_wdata, d_we,
        input  d_gnt, d_rdata, d_valid,
        input  daddr, dwdata, dwe,
        output drdata
    );

endinterface

// File: rtl/dmem_arb.sv
// Data-memory arbiter: one dmem access per cycle, shared between the CPU
// and a debug/loader port. The CPU owns the port by default; a debug request
// takes one cycle whenever the CPU is idle, or after it has been passed over
// STARVE_LIMIT-1 consecutive busy cycles. Debug never gets two cycles in a row.
module dmem_arb
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    dmem_arb_if.slave              bus,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    // Last value wait_cnt reaches before the debug port must be served.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(STARVE_LIMIT - 1);

    owner_e            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              take_dbg;

    // Hand the next cycle to debug when it is pending and either the CPU is
    // idle or debug has already waited its full allowance.
    assign take_dbg = (state == OWN_CPU) && bus.d_req &&
                      (!bus.c_req || (wait_cnt == WAIT_LAST));

    // Owner FSM with its starvation counter.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state is updated with <= so every flop samples pre-edge values.
        if (reset) begin
            state    <= OWN_CPU;
            wait_cnt <= '0;
        end else if (state == OWN_DBG) begin
            // Debug holds the port for exactly one cycle, granted or aborted.
            state    <= OWN_CPU;
            wait_cnt <= '0;
        end else if (take_dbg) begin
            state    <= OWN_DBG;
            wait_cnt <= '0;
        end else if (bus.d_req) begin
            // Debug pending but not taken implies the CPU is busy this cycle.
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Steer the dmem port and requester status from the current owner.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        bus.daddr   = bus.c_addr;
        bus.dwdata  = bus.c_wdata;
        bus.dwe     = 4'b0000;
        bus.c_rdata = bus.drdata;
        bus.c_stall = 1'b0;
        bus.d_gnt   = 1'b0;
        if (state == OWN_DBG) begin
            bus.daddr   = bus.d_addr;
            bus.dwdata  = bus.d_wdata;
            bus.dwe     = bus.d_req ? bus.d_we : 4'b0000;
            bus.d_gnt   = bus.d_req && !reset;
            bus.c_stall = bus.c_req;
        end else if (bus.c_req) begin
            bus.dwe = bus.c_we;
        end
        // No memory write may slip through while reset is held.
        if (reset) begin
            bus.dwe = 4'b0000;
        end
    end

    // Capture debug load data on each grant and pulse d_valid once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.d_rdata <= '0;
            bus.d_valid <= 1'b0;
        end else begin
            bus.d_valid <= bus.d_gnt;
            if (bus.d_gnt) begin
                bus.d_rdata <= bus.drdata;
            end
        end
    end

    // Count CPU stall cycles, holding at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (bus.c_stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_dmem_arb.sv
// Self-checking bench for dmem_arb. A 16-word memory model sits on the dmem
// port; a behavioural reference model predicts ownership, grants, stalls,
// memory contents, debug read data and the saturating stall count from the
// arbitration rules, and every DUT output is compared against it each cycle.
module tb_dmem_arb;

    localparam int LIMIT  = 4;
    localparam int SW     = 4;
    localparam int SW_MAX = (1 << SW) - 1;

    typedef logic [31:0] word_arr_t [16];

    localparam word_arr_t MEM_INIT = '{
        32'h0000_0000, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
        32'h4444_4444, 32'h5555_5555, 32'h6666_6666, 32'h7777_7777,
        32'h8888_8888, 32'h9999_9999, 32'hAAAA_AAAA, 32'hBBBB_BBBB,
        32'hCCCC_CCCC, 32'hDDDD_DDDD, 32'hEEEE_EEEE, 32'hFFFF_FFFF
    };

    logic          clk;
    logic          reset;
    logic [SW-1:0] stall_cnt;

    dmem_arb_if bus ();

    dmem_arb #(
        .STARVE_LIMIT(LIMIT),
        .STALL_CNT_W (SW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: combinational read, byte-enabled write on the rising edge.
    word_arr_t mem = MEM_INIT;
    assign bus.drdata = mem[bus.daddr[5:2]];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (bus.dwe[b]) mem[bus.daddr[5:2]][8*b +: 8] <= bus.dwdata[8*b +: 8];
        end
    end

    // Reference model state
    word_arr_t   ref_mem = MEM_INIT;
    bit          m_dbg;        // debug owns the coming cycle
    int          m_passed;     // busy CPU cycles the pending debug request was passed over
    int          m_stall;
    bit          m_valid;
    logic [31:0] m_rdata;
    int          dbg_wait;     // cycles the current debug request has been pending
    bit          last_stall;
    bit          last_gnt;

    // Raw DUT observations from the most recent cycle, for directed checks.
    logic        obs_gnt;
    logic        obs_stall;
    logic [3:0]  obs_dwe;

    int n_vec;
    int n_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_dbg      = 1'b0;
        m_passed   = 0;
        m_stall    = 0;
        m_valid    = 1'b0;
        m_rdata    = '0;
        dbg_wait   = 0;
        last_stall = 1'b0;
        last_gnt   = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.c_req   = 1'b0;
        bus.c_addr  = '0;
        bus.c_wdata = '0;
        bus.c_we    = 4'h0;
        bus.d_req   = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.d_we    = 4'h0;
    endtask

    // Hold reset across one rising edge, check reset values, release at a falling edge.
    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_d_valid", 32'(bus.d_valid), 32'd0);
        check("rst_d_rdata", bus.d_rdata, 32'd0);
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        check("rst_dwe", 32'(bus.dwe), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // One clock cycle: inputs were applied at the falling edge. Sample the
    // combinational outputs just before the rising edge, the registered ones
    // just after it, and advance the reference model in between.
    task automatic run_cycle();
        logic        e_gnt;
        logic        e_stall;
        logic [3:0]  e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [31:0] rd_old;
        int          idx;

        #4;
        obs_gnt   = bus.d_gnt;
        obs_stall = bus.c_stall;
        obs_dwe   = bus.dwe;

        e_gnt   = m_dbg && bus.d_req;
        e_stall = m_dbg && bus.c_req;
        if (m_dbg) begin
            e_addr  = bus.d_addr;
            e_wdata = bus.d_wdata;
            e_we    = bus.d_req ? bus.d_we : 4'h0;
        end else begin
            e_addr  = bus.c_addr;
            e_wdata = bus.c_wdata;
            e_we    = bus.c_req ? bus.c_we : 4'h0;
        end
        idx = int'(e_addr[5:2]);

        check("d_gnt", 32'(bus.d_gnt), 32'(e_gnt));
        check("c_stall", 32'(bus.c_stall), 32'(e_stall));
        check("dwe", 32'(bus.dwe), 32'(e_we));
        if (e_we != 4'h0 || e_gnt || (!m_dbg && bus.c_req)) check("daddr", bus.daddr, e_addr);
        if (e_we != 4'h0) check("dwdata", bus.dwdata, e_wdata);
        if (!m_dbg && bus.c_req) check("c_rdata", bus.c_rdata, ref_mem[idx]);
        if (e_gnt) check("dbg_latency_ok", 32'(dbg_wait <= LIMIT), 32'd1);

        // Memory effect of this cycle's single access; a read sees pre-write data.
        rd_old = ref_mem[idx];
        for (int b = 0; b < 4; b++) begin
            if (e_we[b]) ref_mem[idx][8*b +: 8] = e_wdata[8*b +: 8];
        end

        // Who owns the next cycle.
        if (m_dbg) begin
            m_dbg    = 1'b0;
            m_passed = 0;
        end else if (bus.d_req && (!bus.c_req || m_passed >= LIMIT - 1)) begin
            m_dbg    = 1'b1;
            m_passed = 0;
        end else if (bus.d_req) begin
            m_passed++;
        end else begin
            m_passed = 0;
        end

        if (e_gnt || !bus.d_req) dbg_wait = 0;
        else dbg_wait++;

        @(posedge clk);
        #1;
        if (e_stall && m_stall < SW_MAX) m_stall++;
        m_valid = e_gnt;
        if (e_gnt) m_rdata = rd_old;
        check("d_valid", 32'(bus.d_valid), 32'(m_valid));
        check("d_rdata", bus.d_rdata, m_rdata);
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall));

        last_stall = e_stall;
        last_gnt   = e_gnt;
        @(negedge clk);
    endtask

    // Random requesters that keep a pending request stable until it is served.
    task automatic drive_random();
        if (!(bus.c_req && last_stall)) begin
            bus.c_req   = ($urandom_range(0, 9) < 6);
            bus.c_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            bus.c_wdata = $urandom;
            bus.c_we    = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
        end
        if (!(bus.d_req && !last_gnt)) begin
            bus.d_req   = ($urandom_range(0, 9) < 4);
            bus.d_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            bus.d_wdata = $urandom;
            bus.d_we    = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
        end
    endtask

    initial begin
        logic [31:0] snap;
        n_vec = 0;
        n_bad = 0;
        model_reset();
        apply_reset();

        // Continuous CPU traffic: debug waits four cycles, granted on the fifth.
        bus.c_req  = 1'b1;
        bus.c_addr = 32'h0000_0008;
        bus.c_we   = 4'h0;
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h0000_0004;
        bus.d_we   = 4'h0;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) bus.d_req = 1'b0;
            run_cycle();
            check($sformatf("starve_gnt_c%0d", i), 32'(obs_gnt), 32'(i == 4));
            check($sformatf("starve_stall_c%0d", i), 32'(obs_stall), 32'(i == 4));
        end
        check("starve_stall_cnt", 32'(stall_cnt), 32'd1);

        // Idle CPU: debug write then read-back of 0x10.
        bus.c_req   = 1'b0;
        bus.d_req   = 1'b1;
        bus.d_addr  = 32'h0000_0010;
        bus.d_wdata = 32'hDEAD_BEEF;
        bus.d_we    = 4'hF;
        run_cycle();
        check("wr_gnt_c0", 32'(obs_gnt), 32'd0);
        run_cycle();
        check("wr_gnt_c1", 32'(obs_gnt), 32'd1);
        check("wr_mem4", mem[4], 32'hDEAD_BEEF);
        bus.d_we = 4'h0;
        run_cycle();
        run_cycle();
        check("rd_gnt", 32'(obs_gnt), 32'd1);
        check("rd_valid", 32'(bus.d_valid), 32'd1);
        check("rd_data", bus.d_rdata, 32'hDEAD_BEEF);
        bus.d_req = 1'b0;
        run_cycle();
        check("rd_valid_drop", 32'(bus.d_valid), 32'd0);
        check("rd_data_hold", bus.d_rdata, 32'hDEAD_BEEF);

        // Debug held high with an idle CPU: grants alternate.
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h0000_0014;
        for (int i = 0; i < 6; i++) begin
            run_cycle();
            check($sformatf("alt_gnt_c%0d", i), 32'(obs_gnt), 32'(i % 2 == 1));
        end

        // Debug drops its request in its own cycle: access aborted.
        bus.d_we    = 4'hF;
        bus.d_addr  = 32'h0000_0018;
        bus.d_wdata = 32'h0BAD_F00D;
        run_cycle();
        bus.d_req = 1'b0;
        run_cycle();
        check("abort_gnt", 32'(obs_gnt), 32'd0);
        check("abort_dwe", 32'(obs_dwe), 32'd0);
        check("abort_valid", 32'(bus.d_valid), 32'd0);
        bus.c_req = 1'b1;
        bus.c_we  = 4'h0;
        run_cycle();
        check("abort_cpu_back", 32'(obs_stall), 32'd0);

        // CPU half-word store colliding with a debug grant lands a cycle later.
        bus.c_req  = 1'b0;
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h0000_0000;
        bus.d_we   = 4'h0;
        run_cycle();
        snap        = mem[8];
        bus.c_req   = 1'b1;
        bus.c_addr  = 32'h0000_0020;
        bus.c_wdata = 32'hA5A5_5A5A;
        bus.c_we    = 4'b0011;
        run_cycle();
        check("st_stalled", 32'(obs_stall), 32'd1);
        check("st_not_yet", mem[8], snap);
        bus.d_req = 1'b0;
        run_cycle();
        check("st_released", 32'(obs_stall), 32'd0);
        check("st_landed", mem[8], {snap[31:16], 16'h5A5A});
        bus.c_req = 1'b0;

        // Both ports saturated: stall counter must stop at all-ones.
        bus.c_req  = 1'b1;
        bus.c_we   = 4'h0;
        bus.d_req  = 1'b1;
        bus.d_we   = 4'h0;
        for (int i = 0; i < 110; i++) run_cycle();
        check("sat_stall_cnt", 32'(stall_cnt), 32'(SW_MAX));

        // Reset asserted while debug owns the port with a full-word write pending.
        idle_inputs();
        run_cycle();
        bus.d_req   = 1'b1;
        bus.d_addr  = 32'h0000_0030;
        bus.d_wdata = 32'h1234_5678;
        bus.d_we    = 4'hF;
        run_cycle();
        snap = mem[12];
        #2;
        reset = 1'b1;
        #1;
        check("rstmid_dwe", 32'(bus.dwe), 32'd0);
        check("rstmid_gnt", 32'(bus.d_gnt), 32'd0);
        @(posedge clk);
        #1;
        check("rstmid_no_write", mem[12], snap);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check("rstmid_valid", 32'(bus.d_valid), 32'd0);
        check("rstmid_stall_cnt", 32'(stall_cnt), 32'd0);
        bus.c_req  = 1'b1;
        bus.c_addr = 32'h0000_0004;
        bus.c_we   = 4'h0;
        run_cycle();
        check("rstmid_cpu_first", 32'(obs_gnt), 32'd0);
        check("rstmid_cpu_nostall", 32'(obs_stall), 32'd0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 1500; i++) begin
            drive_random();
            run_cycle();
        end

        // Final memory image.
        idle_inputs();
        run_cycle();
        for (int i = 0; i < 16; i++) check($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_arb.md
DMEM_ARB -- requirements
Module: dmem_arb

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: max consecutive cycles a pending debug request waits while the CPU holds the port (range 1..15).
REQ-002 Parameter STALL_CNT_W, default 16: width of the stall statistics counter.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 c_req  input  1  CPU data access request (load or store) this cycle.
REQ-006 c_addr  input  32  CPU byte address.
REQ-007 c_wdata  input  32  CPU store data.
REQ-008 c_we  input  4  CPU byte write enables.
REQ-009 c_rdata  output  32  CPU load data.
REQ-010 c_stall  output  1  CPU must hold its request and pipeline this cycle.
REQ-011 d_req  input  1  debug/loader port access request.
REQ-012 d_addr, d_wdata  input  32 each  debug address and store data.
REQ-013 d_we  input  4  debug byte write enables.
REQ-014 d_gnt  output  1  debug access performed this cycle.
REQ-015 d_rdata  output  32  registered debug load data.
REQ-016 d_valid  output  1  one-cycle pulse: d_rdata holds data from the previous granted cycle.
REQ-017 daddr, dwdata  output  32 each  to dmem.
REQ-018 dwe  output  4  to dmem byte write enables.
REQ-019 drdata  input  32  from dmem, combinational read of daddr.
REQ-020 stall_cnt  output  STALL_CNT_W  count of cycles with c_stall high.

Function
REQ-021 Owner FSM: two states, OWN_CPU and OWN_DBG; one access per cycle, owned by the current state.
REQ-022 OWN_CPU: daddr=c_addr, dwdata=c_wdata, dwe=c_we when c_req else 4'b0; c_rdata=drdata; d_gnt=0; c_stall=0.
REQ-023 OWN_DBG: daddr=d_addr, dwdata=d_wdata, dwe=d_we when d_req else 4'b0; d_gnt=d_req; c_stall=c_req; c_rdata is don't-care.
REQ-024 OWN_CPU -> OWN_DBG when d_req and (!c_req or wait_cnt==STARVE_LIMIT-1); else stay.
REQ-025 OWN_DBG -> OWN_CPU unconditionally after one cycle; no back-to-back debug grants.
REQ-026 wait_cnt (4-bit): increments in OWN_CPU when d_req and c_req and no transition; clears on entry to OWN_DBG or when d_req low.
REQ-027 Debug latency: grant within STARVE_LIMIT+1 cycles of d_req rising, under continuous c_req.
REQ-028 d_req dropped while in OWN_DBG: abort; dwe=0, d_gnt=0, no d_valid; return to OWN_CPU.
REQ-029 On d_gnt: d_rdata <= drdata; d_valid=1 the next cycle only; d_rdata holds until the next grant.
REQ-030 Requester handshake: a stalled CPU and an ungranted debug port hold address, data and enables stable.
REQ-031 stall_cnt increments each cycle c_stall=1; saturates at all-ones; no wrap.
REQ-032 All outputs except registered d_rdata, d_valid and stall_cnt are combinational from state and inputs.

Reset
REQ-033 Reset forces: state=OWN_CPU, wait_cnt=0, d_rdata=0, d_valid=0, stall_cnt=0.
REQ-034 Reset mid-grant cancels the debug access; dwe=0 immediately while reset is high.
REQ-035 First cycle after reset deassertion is owned by the CPU.

Structure
REQ-036 Owner state encodings and the STARVE_LIMIT default value live in the shared CPU package/define file.
REQ-037 Single flat module; no sub-module.

Verification
REQ-038 c_req=1 held continuously, d_req=1 at cycle 0 -> d_gnt at cycle 4; c_stall high exactly that cycle; stall_cnt=1.
REQ-039 c_req=0, d_req=1, d_addr=0x10, d_we=4'hF, d_wdata=0xDEADBEEF -> grant next cycle; mem[4]=0xDEADBEEF; debug read of 0x10 gives d_valid with d_rdata=0xDEADBEEF.
REQ-040 d_req held high for 6 cycles with c_req=0 -> d_gnt alternates 0,1,0,1,...; never two consecutive grants.
REQ-041 Reset asserted during OWN_DBG with d_we=4'hF -> no dmem write; after release state=OWN_CPU, d_valid=0, stall_cnt=0.
REQ-042 Force stall_cnt near saturation, with STALL_CNT_W=4 and 20 stall cycles -> stall_cnt=4'hF, no wrap.
REQ-043 CPU store c_we=4'b0011 while debug is granted -> store lands only after c_stall drops; final mem matches expected dump.
